// File: rtl/mru_access_player.sv
// Tick-paced access player: issues one key per permitted tick to the MRU tracker over valid/ready.
// Define ACCESS_LFSR_EN to generate keys from a maximal-length LFSR instead of an up-counter.
module mru_access_player #(
    parameter int KEY_W     = 4,
    parameter int SEQ_LEN   = 16,
    parameter int LFSR_SEED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             pause,
    input  logic             step,
    output logic             acc_valid,
    output logic [KEY_W-1:0] acc_key,
    input  logic             acc_ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      acc_count,
    output logic [7:0]       overrun_count
);

    // state     | meaning
    // S_IDLE    | no run; counters hold last run's results
    // S_WAIT    | run active, waiting for a tick (or a step while paused)
    // S_PRESENT | key presented, waiting for acc_ready
    // S_FINISH  | run complete, done pulse
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic [1:0] S_FINISH  = 2'd3;

`ifdef ACCESS_LFSR_EN
    localparam logic [KEY_W-1:0] KEY_RELOAD = KEY_W'(LFSR_SEED);
`else
    localparam logic [KEY_W-1:0] KEY_RELOAD = '0;
`endif

    function automatic logic [KEY_W-1:0] key_next(input logic [KEY_W-1:0] k);
`ifdef ACCESS_LFSR_EN
        logic [7:0] kp;
        logic       fb;
        kp = 8'(k);
        case (KEY_W)
            3:       fb = kp[2] ^ kp[1];
            4:       fb = kp[3] ^ kp[2];
            5:       fb = kp[4] ^ kp[2];
            6:       fb = kp[5] ^ kp[4];
            7:       fb = kp[6] ^ kp[5];
            default: fb = kp[7] ^ kp[5] ^ kp[4] ^ kp[3];
        endcase
        return {k[KEY_W-2:0], fb};
`else
        return k + KEY_W'(1);
`endif
    endfunction

    logic [1:0]       state_q, state_d;
    logic [KEY_W-1:0] key_gen_q, key_gen_d;
    logic             acc_valid_q, acc_valid_d;
    logic [KEY_W-1:0] acc_key_q, acc_key_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      acc_count_q, acc_count_d;
    logic [7:0]       overrun_q, overrun_d;

    logic        trigger;
    logic        handshake;
    logic [16:0] count_inc;

    assign trigger   = (tick & ~pause) | (step & pause);
    assign handshake = acc_valid_q & acc_ready;
    assign count_inc = {1'b0, acc_count_q} + 17'd1;

    always_comb begin
        state_d     = state_q;
        key_gen_d   = key_gen_q;
        acc_key_d   = acc_key_q;
        acc_count_d = acc_count_q;
        overrun_d   = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WAIT;
                    acc_count_d = '0;
                    overrun_d   = '0;
                    key_gen_d   = KEY_RELOAD;
                end
            end
            S_WAIT: begin
                if (trigger) begin
                    state_d   = S_PRESENT;
                    acc_key_d = key_gen_q;
                end
            end
            S_PRESENT: begin
                // A tick landing on the handshake cycle is still a dropped tick.
                if (tick && !pause && overrun_q != 8'hFF)
                    overrun_d = overrun_q + 8'd1;
                if (handshake) begin
                    acc_count_d = count_inc[15:0];
                    key_gen_d   = key_next(key_gen_q);
                    state_d     = (count_inc == 17'(SEQ_LEN)) ? S_FINISH : S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        acc_valid_d = (state_d == S_PRESENT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            key_gen_q   <= KEY_RELOAD;
            acc_valid_q <= 1'b0;
            acc_key_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            acc_count_q <= '0;
            overrun_q   <= '0;
        end else begin
            state_q     <= state_d;
            key_gen_q   <= key_gen_d;
            acc_valid_q <= acc_valid_d;
            acc_key_q   <= acc_key_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            acc_count_q <= acc_count_d;
            overrun_q   <= overrun_d;
        end
    end

    assign acc_valid     = acc_valid_q;
    assign acc_key       = acc_key_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign acc_count     = acc_count_q;
    assign overrun_count = overrun_q;

endmodule

// File: doc/mru_access_player.md
Name: mru_access_player

Overview:
- Consumer of the one-cycle `tick` pulse from the slow timer stage (one pulse every 25,000,000 clk cycles at 50 MHz).
- Each permitted tick issues one access key to the downstream MRU tracker over a valid/ready handshake.
- Supports start, pause and single-step, counts completed accesses, and counts ticks lost while the downstream stage stalls.

Parameters:
- KEY_W, 4: access key width; legal range 3..8.
- SEQ_LEN, 16: accesses per run; legal range 1..65535.
- LFSR_SEED, 1: LFSR reload value; must be non-zero mod 2^KEY_W. Used only with ACCESS_LFSR_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- tick  in  1  one-cycle pulse from the timer stage
- start  in  1  pulse; begins a run when idle
- pause  in  1  level; blocks tick-triggered accesses
- step  in  1  pulse; triggers one access while paused
- acc_valid  out  1  access key valid
- acc_key  out  KEY_W  access key to the MRU stage
- acc_ready  in  1  downstream accepts key
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- acc_count  out  16  accesses completed in the current run
- overrun_count  out  8  ticks dropped while presenting; saturating

Behaviour:
- Reset values: acc_valid=0, acc_key=0, busy=0, done=0, acc_count=0, overrun_count=0, state=IDLE, key generator reloaded.
- All outputs are registered.
- FSM states: IDLE, WAIT_TICK, PRESENT, FINISH.
- IDLE:
  - start=1 -> WAIT_TICK.
  - On that transition: acc_count<=0, overrun_count<=0, key generator reloaded.
  - tick and step are ignored in IDLE.
- WAIT_TICK:
  - trigger = (tick & ~pause) | (step & pause).
  - On trigger -> PRESENT; acc_valid=1 with acc_key=current key from the next cycle (latency 1 clk).
  - step while not paused is ignored; tick while paused is ignored.
- PRESENT:
  - acc_valid stays 1 and acc_key stays stable until acc_valid & acc_ready.
  - On handshake: acc_valid<=0, acc_count<=acc_count+1, key generator advances.
  - After handshake, if acc_count+1 == SEQ_LEN -> FINISH, else -> WAIT_TICK.
  - pause does not drop acc_valid.
- Overrun:
  - Any tick with pause=0 arriving in PRESENT increments overrun_count, saturating at 255.
  - This includes a tick in the same cycle as the handshake.
  - The tick is discarded, never queued.
- FINISH: done=1 for exactly one cycle, then -> IDLE.
- busy=1 in every state except IDLE.
- start while busy is ignored.
- acc_count and overrun_count hold their values in IDLE until the next start.
- The earliest next access after a handshake is the first tick seen in WAIT_TICK, i.e. at least one cycle after the handshake.
- Reset mid-run: on the rst edge everything returns to reset values; acc_valid drops without a handshake.
- Key arithmetic: the next key is computed modulo 2^KEY_W.

Optional Feature:
- Macro: ACCESS_LFSR_EN.
- Defined:
  - Key generator is a Fibonacci LFSR of KEY_W bits, reloaded to LFSR_SEED, maximal-length taps per KEY_W.
  - Taps (XNOR-free XOR): 3:{3,2}, 4:{4,3}, 5:{5,3}, 6:{6,5}, 7:{7,6}, 8:{8,6,5,4}.
  - acc_key = LFSR state; period 2^KEY_W-1; state never 0.
- Undefined:
  - Key generator is an up-counter reloaded to 0, +1 per handshake, wrapping 2^KEY_W-1 -> 0.

Test Plan:
- Basic run (KEY_W=4, SEQ_LEN=3, counter mode, acc_ready=1):
  - Stimulus: start, then 3 ticks.
  - Response: keys 0,1,2, each valid 1 clk after its tick; done pulses once; acc_count=3; busy falls with done.
- Backpressure:
  - Stimulus: hold acc_ready=0 for 10 cycles after acc_valid rises; inject 2 ticks during the stall.
  - Response: acc_key stable, acc_valid held; overrun_count=2; no extra access issued after release.
- Pause/step:
  - Stimulus: pause=1, then 3 ticks.
  - Response: no acc_valid.
  - Stimulus: one step.
  - Response: one access with key 0, acc_count=1; step with pause=0 ignored.
- Wrap and saturation:
  - Stimulus: SEQ_LEN=20, counter mode.
  - Response: keys 15 then 0 at accesses 16/17.
  - Stimulus: 300 ticks during a stall.
  - Response: overrun_count=255.
- Reset mid-PRESENT:
  - Stimulus: assert rst while acc_valid=1.
  - Response: next cycle all outputs 0, state IDLE; a tick alone does not restart the run.
- ACCESS_LFSR_EN (KEY_W=4, LFSR_SEED=1, SEQ_LEN=15):
  - Response: 15 distinct non-zero keys; first key = 1; start of a second run repeats the same sequence.
